// File: rtl/ones_comp_serial_add.sv
// ones_comp_serial_add
//   Bit-serial 1's-complement adder with end-around carry. It rebuilds the
//   minuend A = D + B (mod 2^WIDTH-1) from a subtractor's difference D and
//   the subtrahend B, one bit per clock and LSB first. It makes two passes:
//     ADD  : WIDTH edges of a ripple add of d and b into the result register
//     WRAP : WIDTH edges that add the main-pass carry back in at the LSB
//   WRAP always runs for the full WIDTH edges, so latency does not depend on
//   the operands.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only in IDLE
//   d, b   operands, latched on the accepting edge
//   busy   high in ADD and WRAP
//   done   one-cycle pulse; a and cout are valid
//   a      reconstructed minuend, held until the next accept
//   cout   carry out of the main pass (the end-around carry that was applied)
module ones_comp_serial_add #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a,
    output logic             cout
);

    typedef enum logic [1:0] {IDLE, ADD, WRAP, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] d_sr, b_sr, r_sr;

    logic last;
    logic add_sum, add_cy;
    logic wrap_sum, wrap_cy;

    assign last     = (cnt == CW'(WIDTH-1));
    assign add_sum  = d_sr[0] ^ b_sr[0] ^ carry;
    assign add_cy   = (d_sr[0] & b_sr[0]) | (d_sr[0] & carry) | (b_sr[0] & carry);
    assign wrap_sum = r_sr[0] ^ carry;
    assign wrap_cy  = r_sr[0] & carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = ADD;
            ADD: begin
                busy = 1'b1;
                if (last) state_nxt = WRAP;
            end
            WRAP: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            d_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            a     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    d_sr  <= d;
                    b_sr  <= b;
                    carry <= 1'b0;
                    cnt   <= '0;
                end
                ADD: begin
                    // Sum bits enter at the MSB, so after WIDTH shifts bit i
                    // sits at position i.
                    r_sr  <= {add_sum, r_sr[WIDTH-1:1]};
                    d_sr  <= d_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= add_cy;
                    if (last) begin
                        cout <= add_cy;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WRAP: begin
                    // Rotate the result through a half adder fed by the wrap carry.
                    r_sr  <= {wrap_sum, r_sr[WIDTH-1:1]};
                    carry <= wrap_cy;
                    if (last) begin
                        a   <= {wrap_sum, r_sr[WIDTH-1:1]};
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // With a wrap carry of 1 the main-pass result is at most 2^WIDTH-2, so
    // the carry out of the last WRAP bit is always 0.
    a_no_wrap_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (state == WRAP && last) |-> !wrap_cy);

endmodule

// File: tb/tb_ones_comp_serial_add.sv
module tb_ones_comp_serial_add;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] d = '0, b = '0;
    logic         busy, done, cout;
    logic [W-1:0] a;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    ones_comp_serial_add #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .d(d), .b(b),
        .busy(busy), .done(done), .a(a), .cout(cout)
    );

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] b;
        logic [W-1:0] a_exp;
        logic         c_exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Entered and left #1 after a posedge, with the DUT in IDLE.
    task automatic run_op(input logic [W-1:0] dv, input logic [W-1:0] bv,
                          output logic [W-1:0] av, output logic cv,
                          output int lat, output logic busy_at_done, output logic got);
        start = 1'b1; d = dv; b = bv;
        @(posedge clk); #1;
        start = 1'b0; d = ~dv; b = ~bv;
        got = 1'b0; lat = 0; av = '0; cv = 1'b0; busy_at_done = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1; lat = j; av = a; cv = cout; busy_at_done = busy;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] ones_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, ~y};
        return s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    endfunction

    initial begin
        logic [W-1:0] av;
        logic         cv, bd, got;
        int           lat, ndone, first, second;

        vecs[0] = '{4'b0011, 4'b0011, 4'b0110, 1'b0};
        vecs[1] = '{4'b1100, 4'b0101, 4'b0010, 1'b1};
        vecs[2] = '{4'b1111, 4'b0000, 4'b1111, 1'b0};
        vecs[3] = '{4'b1111, 4'b1111, 4'b1111, 1'b1};
        vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[5] = '{4'b1010, 4'b0101, 4'b1111, 1'b0};
        vecs[6] = '{4'b0111, 4'b1001, 4'b0001, 1'b1};
        vecs[7] = '{4'b1000, 4'b1000, 4'b0001, 1'b1};

        // reset state
        #12;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_a", a, 0);       chk("rst_cout", cout, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].d, vecs[i].b, av, cv, lat, bd, got);
            chk($sformatf("v%0d_got", i), got, 1);
            chk($sformatf("v%0d_a", i), av, vecs[i].a_exp);
            chk($sformatf("v%0d_cout", i), cv, vecs[i].c_exp);
            chk($sformatf("v%0d_lat", i), lat, 2*W);
            chk($sformatf("v%0d_busy_done", i), bd, 0);
        end
        chk("hold_a", a, 4'b0001);

        // start re-pulsed while busy -> ignored
        start = 1'b1; d = 4'b0011; b = 4'b0011;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; av = '0; lat = 0;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk); #1;
            if (done) begin ndone++; av = a; lat = j; end
            start = (j == 1 || j == 7);
            d = 4'b1100; b = 4'b0101;
        end
        start = 1'b0;
        chk("ign_ndone", ndone, 1);
        chk("ign_a", av, 4'b0110);
        chk("ign_lat", lat, 2*W);
        chk("ign_idle", busy, 0);

        // start held high -> back-to-back period
        start = 1'b1; d = 4'b1100; b = 4'b0101;
        first = -1; second = -1;
        for (int j = 1; j <= 25; j++) begin
            @(posedge clk); #1;
            if (done) begin
                if (first < 0) first = j;
                else if (second < 0) second = j;
            end
        end
        start = 1'b0;
        chk("held_first", first, 2*W+1);
        chk("held_period", second - first, 2*W+2);
        for (int j = 0; j < 12; j++) begin @(posedge clk); #1; end
        chk("held_a", a, 4'b0010);

        // asynchronous reset mid-ADD
        start = 1'b1; d = 4'b0111; b = 4'b1001;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("mid_busy_pre", busy, 1);
        rst_n = 1'b0; #1;
        chk("mid_busy", busy, 0); chk("mid_done", done, 0);
        chk("mid_a", a, 0);       chk("mid_cout", cout, 0);
        #3 rst_n = 1'b1;
        ndone = 0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mid_nodone", ndone, 0);
        run_op(4'b1100, 4'b0101, av, cv, lat, bd, got);
        chk("post_rst_a", av, 4'b0010);
        chk("post_rst_cout", cv, 1);

        // exhaustive restore of A from D = A - B
        ndone = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op(ones_sub(W'(x), W'(y)), W'(y), av, cv, lat, bd, got);
                if (got) ndone++;
                chk($sformatf("exh_%0d_%0d", x, y), int'(av) % 15, x % 15);
            end
        end
        chk("exh_ndone", ndone, 256);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/ones_comp_serial_add.md
Name: ones_comp_serial_add

Overview:
- Bit-serial 1's-complement adder with end-around carry. It is the inverse companion of the team's 4-bit 1's-complement subtractor.
- Given a difference D (from the subtractor) and the subtrahend B, it reconstructs the minuend A = D + B, congruent modulo 2^WIDTH-1.
- Processes one bit per clock, LSB first, in two passes: a main add pass, then an end-around-carry pass.
- Sits beside the combinational subtractor in the Adders library as a low-area check and restore path for self-test of subtraction results.

Parameters:
- WIDTH, 4, operand and result width in bits (>=2).
- CW, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- d  input  WIDTH  difference operand; latched on the accepting edge.
- b  input  WIDTH  subtrahend operand; latched on the accepting edge.
- busy  output  1  high in the ADD and WRAP states.
- done  output  1  one-cycle pulse; a and cout are valid.
- a  output  WIDTH  reconstructed minuend; held from DONE until the next accept.
- cout  output  1  carry out of the main pass, i.e. the end-around carry that was applied.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE; busy=0, done=0, a=0, cout=0; counter, carry and shift registers cleared. Deassertion is sampled synchronously.
- States: IDLE, ADD, WRAP, DONE.
- IDLE:
  - On an edge with start=1: latch d and b into shift registers, carry=0, cnt=0, go to ADD.
  - Otherwise stay in IDLE; a and cout hold their last values.
- ADD, one edge per bit i=cnt:
  - sum_i = d_i ^ b_i ^ carry; carry <= majority(d_i, b_i, carry).
  - sum_i shifts into the result register from the MSB end, so after WIDTH shifts bit i sits at position i.
  - At cnt==WIDTH-1: capture the final carry as cout and as the wrap carry, cnt=0, go to WRAP.
- WRAP, one edge per bit:
  - Serially add the wrap carry into the LSB of the result: r_i ^ c, c <= r_i & c.
  - WRAP always takes WIDTH edges, even when the wrap carry is 0, so latency is constant.
  - At cnt==WIDTH-1: write the result to a, go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE on the next edge. start is ignored in DONE.
- Latency: with the request accepted on edge k, done is high in the cycle after edge k+2*WIDTH. Minimum request-to-request period is 2*WIDTH+2 cycles.
- start while busy or in DONE is ignored; inputs d and b may change freely after acceptance.
- If start is held high continuously, a new operation is accepted on the IDLE edge following DONE.
- The WRAP pass can never overflow: when the wrap carry is 1, the main-pass result is at most 2^WIDTH-2. The carry out of WRAP is discarded and must be provably 0 (assertion).
- Negative-zero rule: the result equals A modulo 2^WIDTH-1. A true zero may be returned as all-ones (e.g. d=1111, b=0000 -> 1111). This is correct behaviour, not an error.
- Reset mid-operation aborts the transaction; no done pulse is produced.

Test Plan:
- d=0011, b=0011 (A=6, B=3) -> after 8 edges: done=1, a=0110, cout=0, busy low again in the DONE cycle.
- d=1100, b=0101 (A=2, B=5) -> a=0010, cout=1 (end-around carry applied in WRAP).
- d=1111, b=0000 -> a=1111, cout=0; d=1111, b=1111 -> a=1111, cout=1 (negative-zero cases, no WRAP overflow).
- start pulsed again at edges 2 and 8 of a transaction -> ignored; exactly one done pulse; a matches the first operands; start held high -> next accept on the IDLE edge after DONE, period 10 cycles.
- rst_n asserted asynchronously mid-ADD -> busy, done, a, cout go to 0 immediately; no done pulse; a fresh start after release completes normally.
- Exhaustive loop over all 256 (A,B) pairs: drive D from a reference model of 1's-complement A-B -> a ≡ A mod 15 for every pair; done pulse count equals 256.
